// File: rtl/clkdiv_multi_pkg.sv
// Shared types, constants and output-level helpers for the multi-channel divider.
package clkdiv_multi_pkg;

   // Output style of a channel: square wave or single-cycle strobe.
   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   // Terminal count every channel starts from after reset.
   localparam int unsigned DEFAULT_FINAL_C = 13_500;

   // Level clk_out takes on a wrap cycle.
   function automatic logic wrap_level(input mode_e mode, input logic cur);
      logic lvl;
      case (mode)
         MODE_TOGGLE: lvl = ~cur;
         MODE_PULSE:  lvl = 1'b1;
         default:     lvl = 1'b0;
      endcase
      return lvl;
   endfunction

   // Level clk_out takes on a non-wrap cycle.
   function automatic logic hold_level(input mode_e mode, input logic cur);
      logic lvl;
      case (mode)
         MODE_TOGGLE: lvl = cur;
         MODE_PULSE:  lvl = 1'b0;
         default:     lvl = 1'b0;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/clkdiv_multi_channel.sv
// One divider channel: wrap counter, shadow/pending config and registered outputs.
// A pending config is applied only on a wrap or while disabled, so the output
// never sees a shortened period; a mode change restarts the channel from zero.
module clkdiv_multi_channel
   import clkdiv_multi_pkg::*;
#(
   parameter int                CNT_W     = 24,
   parameter logic [CNT_W-1:0]  RST_FINAL = {CNT_W{1'b0}}
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] cfg_final_i,
   input  logic             cfg_mode_i,
   output logic             pending_o,
   output logic             clk_out_o,
   output logic             tick_o
);

   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] final_q, final_d;
   logic [CNT_W-1:0] shadow_final_q, shadow_final_d;
   mode_e            mode_q, mode_d;
   mode_e            shadow_mode_q, shadow_mode_d;
   logic             pending_q, pending_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             wrap_s;
   logic             apply_s;

   assign wrap_s  = en_i & (count_q == final_q);
   assign apply_s = pending_q & (wrap_s | ~en_i);

   // Next-state: count/outputs first, then config apply (may override) or capture.
   always_comb begin
      count_d        = count_q;
      final_d        = final_q;
      mode_d         = mode_q;
      shadow_final_d = shadow_final_q;
      shadow_mode_d  = shadow_mode_q;
      pending_d      = pending_q;
      clk_out_d      = clk_out_q;
      tick_d         = 1'b0;

      if (!en_i) begin
         count_d   = ZERO_C;
         tick_d    = 1'b0;
         clk_out_d = 1'b0;
      end else if (wrap_s) begin
         count_d   = ZERO_C;
         tick_d    = 1'b1;
         clk_out_d = wrap_level(mode_q, clk_out_q);
      end else begin
         count_d   = count_q + ONE_C;
         tick_d    = 1'b0;
         clk_out_d = hold_level(mode_q, clk_out_q);
      end

      if (apply_s) begin
         final_d   = shadow_final_q;
         mode_d    = shadow_mode_q;
         pending_d = 1'b0;
         if (shadow_mode_q != mode_q) begin
            clk_out_d = 1'b0;
            count_d   = ZERO_C;
         end else begin
            clk_out_d = clk_out_d;
         end
      end else if (wr_i) begin
         shadow_final_d = cfg_final_i;
         shadow_mode_d  = mode_e'(cfg_mode_i);
         pending_d      = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // State registers with synchronous active-low reset; reset drops any pending write.
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         count_q        <= ZERO_C;
         final_q        <= RST_FINAL;
         mode_q         <= MODE_TOGGLE;
         shadow_final_q <= RST_FINAL;
         shadow_mode_q  <= MODE_TOGGLE;
         pending_q      <= 1'b0;
         clk_out_q      <= 1'b0;
         tick_q         <= 1'b0;
      end else begin
         count_q        <= count_d;
         final_q        <= final_d;
         mode_q         <= mode_d;
         shadow_final_q <= shadow_final_d;
         shadow_mode_q  <= shadow_mode_d;
         pending_q      <= pending_d;
         clk_out_q      <= clk_out_d;
         tick_q         <= tick_d;
      end
   end

   assign pending_o = pending_q;
   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider / tick generator: config decode, ready mux, channel array.
// Writes to a channel index beyond NUM_CH are accepted and discarded.
module clkdiv_multi
   import clkdiv_multi_pkg::*;
#(
   parameter int          NUM_CH        = 4,
   parameter int          CNT_W         = 24,
   parameter int unsigned DEFAULT_FINAL = DEFAULT_FINAL_C,
   parameter int          CH_W          = 2
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_final,
   input  logic              cfg_mode,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] pending_s;
   logic [NUM_CH-1:0] wr_s;
   logic [NUM_CH-1:0] clk_out_s;
   logic [NUM_CH-1:0] tick_s;

   // Ready is the inverse of the addressed channel's pending flag; unmapped channels are always ready.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_ready = (cfg_ch == CH_W'(i)) ? ~pending_s[i] : cfg_ready;
      end
   end

   // One-hot write strobe to the addressed channel on an accepted handshake.
   always_comb begin
      wr_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         wr_s[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_multi_channel #(
         .CNT_W     (CNT_W),
         .RST_FINAL (CNT_W'(DEFAULT_FINAL))
      ) u_ch (
         .clk_in      (clk_in),
         .rst         (rst),
         .en_i        (en[g]),
         .wr_i        (wr_s[g]),
         .cfg_final_i (cfg_final),
         .cfg_mode_i  (cfg_mode),
         .pending_o   (pending_s[g]),
         .clk_out_o   (clk_out_s[g]),
         .tick_o      (tick_s[g])
      );
   end

   assign clk_out = clk_out_s;
   assign tick    = tick_s;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: hand-computed edge counts for each scenario.
module tb_clkdiv_multi;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [3:0]  en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [23:0] cfg_final;
   logic        cfg_mode;
   logic [3:0]  clk_out;
   logic [3:0]  tick;

   int vectors = 0;
   int errors  = 0;

   clkdiv_multi #(
      .NUM_CH        (4),
      .CNT_W         (24),
      .DEFAULT_FINAL (13_500),
      .CH_W          (2)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_final (cfg_final),
      .cfg_mode  (cfg_mode),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; en = 4'b0000; cfg_valid = 1'b0;
      cfg_ch = 2'd0; cfg_final = 24'd0; cfg_mode = 1'b0;
      step(2);
      for (int i = 0; i < 4; i++) begin
         check("rst_clk_out", clk_out[i], 1'b0);
         check("rst_tick", tick[i], 1'b0);
      end
      check("rst_ready", cfg_ready, 1'b1);

      // 1: default terminal count, first rise at edge 13501, fall at 27002
      rst = 1'b1; en = 4'b1111;
      step(13500);
      check("t1_pre_rise", clk_out[0], 1'b0);
      check("t1_pre_tick", tick[0], 1'b0);
      step(1);
      check("t1_rise", clk_out[0], 1'b1);
      check("t1_rise_tick", tick[0], 1'b1);
      check("t1_rise_ch3", clk_out[3], 1'b1);
      step(1);
      check("t1_tick_drop", tick[0], 1'b0);
      check("t1_hold", clk_out[0], 1'b1);
      step(13499);
      check("t1_pre_fall", clk_out[0], 1'b1);
      step(1);
      check("t1_fall", clk_out[0], 1'b0);
      check("t1_fall_tick", tick[0], 1'b1);

      // en low forces outputs to zero
      en = 4'b0000;
      step(1);
      check("en_low_clk", clk_out[3], 1'b0);

      // 2: ch1 final=3 pulse mode -> strobe 1 of every 4 edges
      cfg_ch = 2'd1; cfg_final = 24'd3; cfg_mode = 1'b1; cfg_valid = 1'b1;
      #1;
      check("t2_ready_idle", cfg_ready, 1'b1);
      step(1);
      cfg_valid = 1'b0;
      #1;
      check("t2_ready_pend", cfg_ready, 1'b0);
      step(1);
      check("t2_ready_applied", cfg_ready, 1'b1);
      en[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(1);
         check("t2_tick", tick[1], (k % 4) == 3);
         check("t2_clk", clk_out[1], (k % 4) == 3);
      end

      // 3: ch2 final=0 toggle -> clk/2, then pulse -> stuck high with no runt
      cfg_ch = 2'd2; cfg_final = 24'd0; cfg_mode = 1'b0; cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      step(1);
      en[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1);
         check("t3_div2", clk_out[2], (k % 2) == 0);
         check("t3_tick", tick[2], 1'b1);
      end
      cfg_mode = 1'b1; cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      check("t3_old_mode", clk_out[2], 1'b1);
      step(1);
      check("t3_mode_clear", clk_out[2], 1'b0);
      check("t3_mode_tick", tick[2], 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1);
         check("t3_stuck", clk_out[2], 1'b1);
      end

      // 4: ch0 final=9, back-to-back writes 5 then 7
      cfg_ch = 2'd0; cfg_final = 24'd9; cfg_mode = 1'b0; cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      step(1);
      en[0] = 1'b1;
      step(2);
      cfg_final = 24'd5; cfg_valid = 1'b1;
      #1;
      check("t4_ready_w1", cfg_ready, 1'b1);
      step(1);
      cfg_final = 24'd7;
      #1;
      check("t4_ready_blocked", cfg_ready, 1'b0);
      step(6);
      check("t4_ready_still_blocked", cfg_ready, 1'b0);
      step(1);
      check("t4_wrap1_ready", cfg_ready, 1'b1);
      check("t4_wrap1_clk", clk_out[0], 1'b1);
      check("t4_wrap1_tick", tick[0], 1'b1);
      step(1);
      cfg_valid = 1'b0;
      #1;
      check("t4_w2_pending", cfg_ready, 1'b0);
      step(4);
      check("t4_hold_high", clk_out[0], 1'b1);
      step(1);
      check("t4_wrap2_clk", clk_out[0], 1'b0);
      check("t4_wrap2_tick", tick[0], 1'b1);
      check("t4_wrap2_ready", cfg_ready, 1'b1);
      step(7);
      check("t4_hold_low", clk_out[0], 1'b0);
      check("t4_hold_tick", tick[0], 1'b0);
      step(1);
      check("t4_wrap3_clk", clk_out[0], 1'b1);
      check("t4_wrap3_tick", tick[0], 1'b1);

      // 5: ch3 final=5, write 2 on the exact wrap edge -> 6 then 3
      cfg_ch = 2'd3; cfg_final = 24'd5; cfg_mode = 1'b0; cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      step(1);
      en[3] = 1'b1;
      step(5);
      cfg_final = 24'd2; cfg_valid = 1'b1;
      #1;
      check("t5_ready", cfg_ready, 1'b1);
      step(1);
      cfg_valid = 1'b0;
      check("t5_wrap_a", tick[3], 1'b1);
      #1;
      check("t5_pending", cfg_ready, 1'b0);
      step(5);
      check("t5_no_early", tick[3], 1'b0);
      step(1);
      check("t5_wrap_b", tick[3], 1'b1);
      check("t5_applied", cfg_ready, 1'b1);
      step(2);
      check("t5_short_gap", tick[3], 1'b0);
      step(1);
      check("t5_wrap_c", tick[3], 1'b1);

      // 6: drop en mid-period, then reset with a pending write
      check("t6_pre_drop", clk_out[2], 1'b1);
      en[2] = 1'b0;
      step(1);
      check("t6_drop_clk", clk_out[2], 1'b0);
      check("t6_drop_tick", tick[2], 1'b0);
      cfg_ch = 2'd0; cfg_final = 24'd2; cfg_mode = 1'b1; cfg_valid = 1'b1;
      step(1);
      cfg_valid = 1'b0;
      #1;
      check("t6_pending", cfg_ready, 1'b0);
      rst = 1'b0;
      step(1);
      for (int i = 0; i < 4; i++) begin
         check("t6_rst_clk", clk_out[i], 1'b0);
         check("t6_rst_tick", tick[i], 1'b0);
      end
      check("t6_rst_ready", cfg_ready, 1'b1);
      rst = 1'b1; en = 4'b0011;
      step(3);
      check("t6_dropped_write", tick[0], 1'b0);
      step(13497);
      check("t6_def_pre0", clk_out[0], 1'b0);
      check("t6_def_pre1", clk_out[1], 1'b0);
      step(1);
      check("t6_def_rise0", clk_out[0], 1'b1);
      check("t6_def_rise1", clk_out[1], 1'b1);
      check("t6_def_tick1", tick[1], 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
